// File: rtl/physical_free_list_pkg.sv
// Shared rename-stage sizing for the physical register free list.
// Replaces the old `PREG_W/`PHYS_REGS/`ARCH_REGS/`RENAME_WIDTH header macros.
package physical_free_list_pkg;

    localparam int WIDTH     = 3;
    localparam int PHYS_REGS = 64;
    localparam int ARCH_REGS = 15;
    localparam int PREG_W    = $clog2(PHYS_REGS);

    typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/physical_free_list_if.sv
// Rename allocate port and retire release port of the free list.
interface physical_free_list_if #(
    parameter int WIDTH  = physical_free_list_pkg::WIDTH,
    parameter int PREG_W = physical_free_list_pkg::PREG_W
);

    logic [WIDTH-1:0]        alloc_req_i;
    logic                    alloc_ready_o;
    logic [WIDTH*PREG_W-1:0] alloc_preg_o;
    logic [WIDTH-1:0]        rel_valid_i;
    logic [WIDTH*PREG_W-1:0] rel_preg_i;
    logic [PREG_W:0]         free_count_o;
    logic                    overflow_o;

    modport master (
        output alloc_req_i, rel_valid_i, rel_preg_i,
        input  alloc_ready_o, alloc_preg_o, free_count_o, overflow_o
    );

    modport slave (
        input  alloc_req_i, rel_valid_i, rel_preg_i,
        output alloc_ready_o, alloc_preg_o, free_count_o, overflow_o
    );

endinterface

// File: rtl/physical_free_list_prefix.sv
// Exclusive prefix popcount of a request vector plus its total, used to
// compact per-slot FIFO offsets.
module physical_free_list_prefix #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 2
) (
    input  logic [WIDTH-1:0]            vec_i,
    output logic [WIDTH-1:0][CNT_W-1:0] excl_o,
    output logic [CNT_W-1:0]            total_o
);

    logic [CNT_W-1:0] sum;

    always_comb begin
        sum    = '0;
        excl_o = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            excl_o[k] = sum;
            sum       = sum + CNT_W'(vec_i[k]);
        end
        total_o = sum;
    end

endmodule

// File: rtl/physical_free_list.sv
// Physical register free list: circular FIFO of free tags with a WIDTH-wide
// allocate port (combinational grant) and an independent WIDTH-wide release port.
module physical_free_list #(
    parameter int WIDTH     = physical_free_list_pkg::WIDTH,
    parameter int PHYS_REGS = physical_free_list_pkg::PHYS_REGS,
    parameter int ARCH_REGS = physical_free_list_pkg::ARCH_REGS,
    parameter int PREG_W    = physical_free_list_pkg::PREG_W
) (
    input logic                clk,
    input logic                rst,
    physical_free_list_if.slave fl
);

    import physical_free_list_pkg::*;

    localparam int CNT_W    = $clog2(WIDTH + 1);
    localparam int CW       = PREG_W + 1;
    localparam int SW       = PREG_W + 2;
    localparam int RST_FREE = PHYS_REGS - ARCH_REGS;

    logic [PREG_W-1:0] entry_q [PHYS_REGS];
    logic [PREG_W-1:0] entry_d [PHYS_REGS];
    logic [PREG_W-1:0] head_q, head_d;
    logic [PREG_W-1:0] tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;

    logic [WIDTH-1:0][CNT_W-1:0] alloc_pre, rel_pre;
    logic [CNT_W-1:0]            alloc_n, rel_n;
    logic                        alloc_ready, alloc_fire, rel_drop;
    logic [SW-1:0]               count_after;

    physical_free_list_prefix #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_alloc_prefix (
        .vec_i   (fl.alloc_req_i),
        .excl_o  (alloc_pre),
        .total_o (alloc_n)
    );

    physical_free_list_prefix #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_rel_prefix (
        .vec_i   (fl.rel_valid_i),
        .excl_o  (rel_pre),
        .total_o (rel_n)
    );

    // Grant uses start-of-cycle state only, so released tags are never bypassed.
    always_comb begin
        alloc_ready     = !rst && (count_q >= CW'(alloc_n));
        alloc_fire      = alloc_ready && (|fl.alloc_req_i);
        fl.alloc_preg_o = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (!rst && fl.alloc_req_i[k]) begin
                fl.alloc_preg_o[k*PREG_W +: PREG_W] = entry_q[head_q + PREG_W'(alloc_pre[k])];
            end
        end
    end

    always_comb begin
        count_after = SW'(count_q) - (alloc_fire ? SW'(alloc_n) : '0) + SW'(rel_n);
        rel_drop    = count_after > SW'(PHYS_REGS);
        head_d      = alloc_fire ? head_q + PREG_W'(alloc_n) : head_q;
        entry_d     = entry_q;
        tail_d      = tail_q;
        count_d     = CW'(count_after);
        overflow_d  = overflow_q;
        // An over-full release is dropped as a whole; the allocate still pops.
        if (rel_drop) begin
            count_d    = CW'(count_after - SW'(rel_n));
            overflow_d = 1'b1;
        end else begin
            tail_d = tail_q + PREG_W'(rel_n);
            for (int unsigned k = 0; k < WIDTH; k++) begin
                if (fl.rel_valid_i[k]) begin
                    entry_d[tail_q + PREG_W'(rel_pre[k])] = fl.rel_preg_i[k*PREG_W +: PREG_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PHYS_REGS; i++) begin
                entry_q[i] <= (i < RST_FREE) ? PREG_W'(i + ARCH_REGS) : '0;
            end
            head_q     <= '0;
            tail_q     <= PREG_W'(RST_FREE);
            count_q    <= CW'(RST_FREE);
            overflow_q <= 1'b0;
        end else begin
            entry_q    <= entry_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign fl.alloc_ready_o = alloc_ready;
    assign fl.free_count_o  = count_q;
    assign fl.overflow_o    = overflow_q;

endmodule
